// File: rtl/alarm_controller.sv
// Eight-zone intruder alarm sequencer: arm/exit/entry/siren/acknowledge with fixed-priority latch.
// Optional door chime while disarmed is built only when ALARM_CHIME_EN is defined.
module alarm_controller #(
  parameter int unsigned EXIT_DELAY  = 16,
  parameter int unsigned ENTRY_DELAY = 32,
  parameter int unsigned SIREN_TIME  = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:8] zone_i,
  input  logic       arm_i,
  input  logic       disarm_i,
  input  logic       ack_i,
  output logic       armed_o,
  output logic       exit_pending_o,
  output logic       entry_pending_o,
  output logic       siren_o,
  output logic       alarm_valid_o,
  output logic [2:0] alarm_zone_o,
  output logic       chime_o
);

  typedef enum logic [2:0] {
    StDisarmed,
    StExit,
    StArmed,
    StEntry,
    StAlarm,
    StSilenced
  } state_e;

  localparam logic [CNT_W-1:0] ExitLoad  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SirenLoad = CNT_W'(SIREN_TIME - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:8]       zone_q;
  logic             valid_q, valid_d;
  logic [2:0]       code_q, code_d;
  logic             any_trip, hi_trip;
  logic [2:0]       win_code, hi_code;

  // Scan from zone 8 down so the lowest-numbered tripped zone is written last.
  always_comb begin
    win_code = '0;
    hi_code  = '0;
    for (int i = 8; i >= 1; i--) begin
      if (zone_q[i]) win_code = 3'(i - 1);
      if (i >= 2 && zone_q[i]) hi_code = 3'(i - 1);
    end
  end

  assign any_trip = |zone_q;
  assign hi_trip  = |zone_q[2:8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    code_d  = code_q;
    if (disarm_i) begin
      state_d = StDisarmed;
      cnt_d   = '0;
      valid_d = 1'b0;
      code_d  = '0;
    end else if (ack_i && (state_q == StAlarm || state_q == StSilenced)) begin
      state_d = StArmed;
      cnt_d   = '0;
      valid_d = 1'b0;
      code_d  = '0;
    end else begin
      case (state_q)
        StDisarmed: begin
          if (arm_i) begin
            state_d = StExit;
            cnt_d   = ExitLoad;
          end
        end
        StExit: begin
          if (cnt_q == '0) state_d = StArmed;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        StArmed: begin
          if (any_trip) begin
            if (zone_q[1]) begin
              state_d = StEntry;
              cnt_d   = EntryLoad;
            end else begin
              state_d = StAlarm;
              cnt_d   = SirenLoad;
              valid_d = 1'b1;
              code_d  = win_code;
            end
          end
        end
        StEntry: begin
          // Any non-door zone cuts the entry grace short.
          if (hi_trip || cnt_q == '0) begin
            state_d = StAlarm;
            cnt_d   = SirenLoad;
            valid_d = 1'b1;
            code_d  = hi_trip ? hi_code : 3'd0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StAlarm: begin
          if (cnt_q == '0) state_d = StSilenced;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        StSilenced: ;
        default: state_d = StDisarmed;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StDisarmed;
      cnt_q           <= '0;
      zone_q          <= '0;
      valid_q         <= 1'b0;
      code_q          <= '0;
      armed_o         <= 1'b0;
      exit_pending_o  <= 1'b0;
      entry_pending_o <= 1'b0;
      siren_o         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      zone_q          <= zone_i;
      valid_q         <= valid_d;
      code_q          <= code_d;
      armed_o         <= (state_d == StArmed) || (state_d == StEntry) ||
                         (state_d == StAlarm) || (state_d == StSilenced);
      exit_pending_o  <= (state_d == StExit);
      entry_pending_o <= (state_d == StEntry);
      siren_o         <= (state_d == StAlarm);
    end
  end

  assign alarm_valid_o = valid_q;
  assign alarm_zone_o  = code_q;

`ifdef ALARM_CHIME_EN
  logic [1:8] zone_prev_q;
  logic       chime_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zone_prev_q <= '0;
      chime_q     <= 1'b0;
    end else begin
      zone_prev_q <= zone_q;
      chime_q     <= (state_q == StDisarmed) && (|(zone_q & ~zone_prev_q));
    end
  end

  assign chime_o = chime_q;
`else
  assign chime_o = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus random stimulus
// compared every cycle against a phase/timestamp model of the alarm sequence.
module tb_alarm_controller;

  localparam int unsigned ExitD  = 4;
  localparam int unsigned EntryD = 6;
  localparam int unsigned SirenT = 10;
`ifdef ALARM_CHIME_EN
  localparam bit ChimeOn = 1'b1;
`else
  localparam bit ChimeOn = 1'b0;
`endif

  localparam int MDis = 0, MExit = 1, MArmed = 2, MEntry = 3, MAlarm = 4, MSil = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:8] zone;
  logic       arm, disarm, ack;
  logic       armed, exit_pending, entry_pending, siren, alarm_valid, chime;
  logic [2:0] alarm_zone;

  always #5 clk = ~clk;

  alarm_controller #(
    .EXIT_DELAY (ExitD),
    .ENTRY_DELAY(EntryD),
    .SIREN_TIME (SirenT),
    .CNT_W      (8)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .zone_i         (zone),
    .arm_i          (arm),
    .disarm_i       (disarm),
    .ack_i          (ack),
    .armed_o        (armed),
    .exit_pending_o (exit_pending),
    .entry_pending_o(entry_pending),
    .siren_o        (siren),
    .alarm_valid_o  (alarm_valid),
    .alarm_zone_o   (alarm_zone),
    .chime_o        (chime)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: current mode, edge number at which it was entered, latch.
  int       m_mode, m_start, m_edges, m_code;
  bit [1:8] m_zq, m_zprev;
  bit       m_valid, m_chime;

  function automatic int lowest(input bit [1:8] v, input int from);
    for (int i = from; i <= 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [8:0] exp_vec();
    logic a;
    a = (m_mode == MArmed) || (m_mode == MEntry) || (m_mode == MAlarm) || (m_mode == MSil);
    return {a, m_mode == MExit, m_mode == MEntry, m_mode == MAlarm, m_valid, 3'(m_code), m_chime};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {armed, exit_pending, entry_pending, siren, alarm_valid, alarm_zone, chime};
  endfunction

  task automatic model_reset();
    m_mode  = MDis;
    m_start = m_edges;
    m_zq    = '0;
    m_zprev = '0;
    m_valid = 1'b0;
    m_code  = 0;
    m_chime = 1'b0;
  endtask

  task automatic latch(input int code);
    m_valid = 1'b1;
    m_code  = code;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit [1:8] zq;
    int       el, nm;
    m_edges++;
    zq      = m_zq;
    el      = m_edges - m_start;
    nm      = m_mode;
    m_chime = ChimeOn && (m_mode == MDis) && ((zq & ~m_zprev) != '0);
    if (disarm) begin
      nm = MDis;
      m_valid = 1'b0;
      m_code = 0;
    end else if (ack && (m_mode == MAlarm || m_mode == MSil)) begin
      nm = MArmed;
      m_valid = 1'b0;
      m_code = 0;
    end else begin
      case (m_mode)
        MDis:   if (arm) nm = MExit;
        MExit:  if (el == int'(ExitD)) nm = MArmed;
        MArmed: begin
          if (lowest(zq, 1) == 1) nm = MEntry;
          else if (lowest(zq, 1) != 0) begin
            nm = MAlarm;
            latch(lowest(zq, 1) - 1);
          end
        end
        MEntry: begin
          if (lowest(zq, 2) != 0) begin
            nm = MAlarm;
            latch(lowest(zq, 2) - 1);
          end else if (el == int'(EntryD)) begin
            nm = MAlarm;
            latch(0);
          end
        end
        MAlarm: if (el == int'(SirenT)) nm = MSil;
        default: ;
      endcase
    end
    if (nm != m_mode) m_start = m_edges;
    m_mode  = nm;
    m_zprev = zq;
    m_zq    = zone;
  endtask

  // Called at a falling edge; drives inputs, advances model, checks at next falling edge.
  task automatic step(input bit a, input bit d, input bit k, input bit [1:8] z);
    arm    = a;
    disarm = d;
    ack    = k;
    zone   = z;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("outs", 16'(dut_vec()), 16'(exp_vec()));
  endtask

  task automatic idle(input int n, input bit [1:8] z);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, z);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_async", 16'(dut_vec()), 16'(exp_vec()));
    check("reset_zero", 16'(dut_vec()), 16'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    arm    = 1'b0;
    disarm = 1'b0;
    ack    = 1'b0;
  endtask

  initial begin
    bit [1:8] z;
    bit       a, d, k;
    rst_n   = 1'b0;
    arm     = 1'b0;
    disarm  = 1'b0;
    ack     = 1'b0;
    zone    = '0;
    m_edges = 0;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Arm and run through exit delay.
    step(1'b1, 1'b0, 1'b0, '0);
    check("exit_pending", 16'(exit_pending), 16'h1);
    idle(ExitD, '0);
    check("armed_after_exit", 16'({armed, exit_pending, siren, alarm_valid}), 16'b1000);

    // Zones 3 and 6 together, then siren timeout.
    step(1'b0, 1'b0, 1'b0, 8'b0010_0100);
    step(1'b0, 1'b0, 1'b0, 8'b0010_0100);
    check("prio_zone", 16'({siren, alarm_valid, alarm_zone}), 16'b1_1_010);
    idle(SirenT, '0);
    check("siren_timeout", 16'({siren, alarm_valid, alarm_zone}), 16'b0_1_010);
    step(1'b0, 1'b0, 1'b1, '0);

    // Entry door, disarm mid-grace.
    step(1'b0, 1'b0, 1'b0, 8'b1000_0000);
    step(1'b0, 1'b0, 1'b0, '0);
    check("entry_pending", 16'(entry_pending), 16'h1);
    idle(3, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("disarm_entry", 16'(dut_vec()), 16'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(ExitD, '0);

    // Entry interrupted by zone 5.
    step(1'b0, 1'b0, 1'b0, 8'b1000_0000);
    idle(2, '0);
    step(1'b0, 1'b0, 1'b0, 8'b0000_1000);
    step(1'b0, 1'b0, 1'b0, '0);
    check("entry_cut", 16'({siren, alarm_valid, alarm_zone}), 16'b1_1_100);
    step(1'b0, 1'b0, 1'b1, '0);

    // Entry grace expiring.
    step(1'b0, 1'b0, 1'b0, 8'b1000_0000);
    step(1'b0, 1'b0, 1'b0, '0);
    idle(EntryD - 1, '0);
    check("entry_wait", 16'({entry_pending, siren}), 16'b10);
    step(1'b0, 1'b0, 1'b0, '0);
    check("entry_expire", 16'({siren, alarm_valid, alarm_zone}), 16'b1_1_000);
    step(1'b0, 1'b0, 1'b1, '0);

    // Ack with zone 7 still tripped, then disarm+ack together.
    idle(2, 8'b0000_0010);
    check("zone7_alarm", 16'({alarm_valid, alarm_zone}), 16'b1_110);
    step(1'b0, 1'b0, 1'b1, 8'b0000_0010);
    check("ack_clear", 16'({armed, siren, alarm_valid}), 16'b100);
    step(1'b0, 1'b0, 1'b0, 8'b0000_0010);
    check("retrip", 16'({siren, alarm_valid, alarm_zone}), 16'b1_1_110);
    step(1'b0, 1'b1, 1'b1, 8'b0000_0010);
    check("disarm_over_ack", 16'({armed, siren, alarm_valid}), 16'b000);

    // Chime while disarmed.
    idle(2, '0);
    step(1'b0, 1'b0, 1'b0, 8'b0100_0000);
    step(1'b0, 1'b0, 1'b0, 8'b0100_0000);
    check("chime_pulse", 16'(chime), 16'(ChimeOn));
    step(1'b0, 1'b0, 1'b0, 8'b0100_0000);
    check("chime_single", 16'(chime), 16'h0);
    idle(2, '0);

    // Random phase.
    z = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        a = ($urandom_range(0, 5) == 0);
        d = ($urandom_range(0, 80) == 0);
        k = ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0) begin
            z = '0;
            z[$urandom_range(1, 8)] = 1'b1;
          end else begin
            z = 8'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          z = '0;
        end
        step(a, d, k, z);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequential controller for the eight-zone intruder alarm. It registers the zone sensor inputs and resolves simultaneous trips with the fixed priority rule: lowest-numbered zone wins, reported as a 3-bit code. It runs the arm, exit-delay, entry-delay, siren and acknowledge sequence, and latches the first winning zone until the alarm is acknowledged or the system is disarmed. It sits between the raw zone sensors and the keypad/siren drivers.

## Interface
- EXIT_DELAY, 16: cycles spent in EXIT after arming; 1 ≤ value < 2^CNT_W.
- ENTRY_DELAY, 32: cycles of grace after zone 1 (entry door) trips while armed; 1 ≤ value < 2^CNT_W.
- SIREN_TIME, 64: cycles siren stays on before auto-silence; 1 ≤ value < 2^CNT_W.
- CNT_W, 8: width of the shared down-counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- zone  input  [1:8]  sensor levels; 1 = zone tripped; zone[1] is highest priority.
- arm  input  1  keypad arm request, sampled each cycle.
- disarm  input  1  keypad disarm request, sampled each cycle.
- ack  input  1  alarm acknowledge, sampled each cycle.
- armed  output  1  high in ARMED, ENTRY, ALARM and SILENCED.
- exit_pending  output  1  high in EXIT.
- entry_pending  output  1  high in ENTRY.
- siren  output  1  high in ALARM.
- alarm_valid  output  1  a zone is latched.
- alarm_zone  output  3  latched zone code = zone number − 1 (zone 1 → 0, zone 8 → 7).
- chime  output  1  one-cycle pulse; see Configuration.

## Operation
- zone is registered into zone_q every cycle. All decisions use zone_q.
- Winner: the lowest index i with zone_q[i] = 1; any = OR of zone_q.
- States: DISARMED, EXIT, ARMED, ENTRY, ALARM, SILENCED. All outputs are registered.
- Command priority in every state: disarm > ack > arm.
- disarm in any state → DISARMED. It clears alarm_valid and alarm_zone to 0 and the counter to 0.
- DISARMED: arm → EXIT, counter loaded with EXIT_DELAY−1. Zones are ignored.
- EXIT: the counter decrements each cycle. At count 0 → ARMED. Zones are ignored during EXIT.
- ARMED:
  - any with winner = zone 1 → ENTRY, counter loaded with ENTRY_DELAY−1.
  - any with winner ≥ 2 → ALARM, latch code, counter loaded with SIREN_TIME−1.
- ENTRY:
  - zone_q[2:8] nonzero → ALARM immediately, latching the lowest tripped zone among 2–8.
  - Otherwise at count 0 → ALARM, latching code 0.
  - Zone 1 clearing does not cancel ENTRY.
- ALARM: at count 0 → SILENCED. The latch is held. New zone trips never overwrite the latch.
- ALARM or SILENCED: ack → ARMED and clears the latch. If zones are still tripped, ARMED re-evaluates them on the next cycle.
- arm outside DISARMED and ack outside ALARM/SILENCED are ignored.

## Timing
- Reset values: state DISARMED; zone_q, counter, armed, exit_pending, entry_pending, siren, alarm_valid, alarm_zone and chime all 0.
- Zone latency: zone sampled at edge N → zone_q at N. The state and output change at edge N+1, so the output is visible two edges after zone is applied.
- Command latency: arm, disarm or ack sampled at edge N → state and outputs updated at edge N.
- Timed states (EXIT, ENTRY, ALARM) last exactly their parameter in cycles, counted from the entry edge.
- Simultaneous trips resolve by priority in the same cycle. Example: zone_q = zones 3 and 6 → code 2.
- Reset asserted mid-sequence returns everything to reset values immediately. On release the block stays in DISARMED until arm.

## Configuration
- ALARM_CHIME_EN defined:
  - In DISARMED, a 0→1 transition of any zone_q bit (compared with its previous value) pulses chime for exactly one cycle.
  - Several bits rising in the same cycle give a single pulse.
  - chime stays 0 in all other states.
- ALARM_CHIME_EN undefined: chime is tied to 0 and the edge-detect register is not built.

## Test plan
- Reset, arm pulse, EXIT_DELAY=4 → exit_pending high 4 cycles, then armed=1 with siren=0 and alarm_valid=0.
- Armed, zone = 8'b0010_0100 (zones 3 and 6) → siren=1 two edges later, alarm_valid=1, alarm_zone=2. After SIREN_TIME=10 cycles siren=0 and alarm_zone stays 2.
- Armed, zone 1 trips, ENTRY_DELAY=6, disarm at cycle 4 → entry_pending drops, all outputs 0, siren never asserts.
- Armed, zone 1 trips, zone 5 trips 2 cycles later → immediate ALARM with alarm_zone=4. Separately, zone 1 alone → ALARM after 6 cycles with alarm_zone=0.
- ALARM with zone 7 still tripped, ack → armed=1, alarm_valid=0 for one cycle, then re-trip to alarm_zone=6. Same scenario with disarm and ack asserted together → DISARMED.
- With ALARM_CHIME_EN: disarmed, zone 2 rises → chime high exactly one cycle. The same stimulus while armed → chime stays 0. Without the macro, chime is always 0.
